if_id_skid_reg: RTL

- Parametrised IF/ID pipeline boundary register with a valid/ready handshake on both sides, replacing the free-running IF/ID latch.
- Adds a 2-entry skid buffer, a synchronous flush for branch/exception redirect, and NOP bubble insertion.
- Adds a saturating backpressure counter.
- Sits between fetch (upstream producer) and decode (downstream consumer).

---
 rtl/if_id_skid_reg_pkg.sv | 29 ++
 rtl/if_id_skid_reg_if.sv | 37 +++
 rtl/if_id_skid_reg_skid_buffer.sv | 118 +++++++++++
 rtl/if_id_skid_reg.sv | 85 ++++++++
 4 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the IF/ID pipeline boundary.
//   XLEN / ILEN      : default PC and instruction widths
//   NOP_INSTR        : addi x0,x0,0, shown to decode when no entry is valid
//   if_id_payload_t  : one fetched instruction with its PC and predictor hint
//   skid_state_e     : occupancy of the two-entry skid buffer
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } if_id_payload_t;

  // EMPTY: nothing held; ONE: main entry valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg_if
// Fetch-side and decode-side handshake bundle of the IF/ID register.
//   in_valid/in_ready, instr_in, pc_in, pred_taken_in        : fetch -> register
//   out_valid/out_ready, instr_out, pc_out, pred_taken_out   : register -> decode
// Modports:
//   slave  : the IF/ID register itself
//   master : the surrounding pipeline (fetch + decode)
// -----------------------------------------------------------------------------
interface if_id_skid_reg_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] instr_in;
  logic [XLEN-1:0] pc_in;
  logic            pred_taken_in;

  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic            pred_taken_out;

  modport slave (
    input  in_valid, instr_in, pc_in, pred_taken_in, out_ready,
    output in_ready, out_valid, instr_out, pc_out, pred_taken_out
  );

  modport master (
    output in_valid, instr_in, pc_in, pred_taken_in, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, pred_taken_out
  );

endinterface

// File: rtl/if_id_skid_reg_skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Generic valid/ready register slice with an optional second (skid) entry and
// a synchronous flush.
//   clk, rst_n               : clock, asynchronous active-low reset
//   flush_i                  : drop every held entry and any same-cycle enqueue
//   in_valid_i/in_ready_o    : producer handshake, in_data_i sampled on enqueue
//   out_valid_o/out_ready_i  : consumer handshake, out_data_o is the main entry
// SKID_EN=1: two entries, in_ready_o comes straight from a flop.
// SKID_EN=0: one entry, in_ready_o = !out_valid_o || out_ready_i.
// out_data_o keeps the last main entry after it drains or is flushed; the
// caller decides what to present while out_valid_o is low.
// -----------------------------------------------------------------------------
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         enq, deq;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = m_q;
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;

  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned -- that is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      // Flush wins: a same-cycle dequeue has already happened on the consumer
      // side, and a same-cycle enqueue is simply not captured.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d = ONE;
            m_d     = in_data_i;
          end
        end
        ONE: begin
          if (enq && deq) begin
            m_d = in_data_i;
          end else if (enq) begin
            // Only reachable with the skid entry present; without it in_ready
            // is low whenever ONE is stalled.
            state_d = FULL;
            s_d     = in_data_i;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are reset as well as the state, because the
  // idle outputs (pc_out, pred_taken_out) are defined right after reset.
  // NOTE: sequential state is updated with <= so all flops sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

  if (SKID_EN) begin : g_skid
    logic in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q        <= '0;
        in_ready_q <= 1'b1;
      end else begin
        s_q        <= s_d;
        in_ready_q <= (state_d != FULL);
      end
    end

    assign in_ready_o = in_ready_q;
  end else begin : g_no_skid
    logic unused_s_d;

    assign s_q        = '0;
    assign unused_s_d = ^s_d;
    assign in_ready_o = !out_valid_o || out_ready_i;
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline boundary register with valid/ready on both sides.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : branch/exception redirect, empties the register
//   bus (slave) : fetch handshake (in_*) and decode handshake (out_*)
//   stall_cnt   : saturating count of cycles with out_valid && !out_ready
// Wraps skid_buffer and adds the NOP bubble on instr_out, the predictor-hint
// clearing after a flush, and the backpressure counter.
// -----------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int              XLEN        = pipe_pkg::XLEN,
  parameter int              ILEN        = pipe_pkg::ILEN,
  parameter logic [ILEN-1:0] NOP_INSTR   = ILEN'(pipe_pkg::NOP_INSTR),
  parameter bit              SKID_EN     = 1'b1,
  parameter int              STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  if_id_skid_reg_if.slave        bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PW = ILEN + XLEN + 1;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } payload_t;

  payload_t                 in_pl;
  payload_t                 m_pl;
  logic                     m_valid;
  logic                     flushed_q;
  logic [STALL_CNT_W-1:0]   stall_q;

  assign in_pl = '{instr: bus.instr_in, pc: bus.pc_in, pred_taken: bus.pred_taken_in};

  skid_buffer #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (m_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (m_pl)
  );

  // Idle bubble: decode sees a NOP whenever nothing valid is held. pc_out
  // keeps the last entry's PC; the hint keeps its value after a normal drain
  // but is forced low after a flush until the next valid entry shows up.
  assign bus.out_valid      = m_valid;
  assign bus.instr_out      = m_valid ? m_pl.instr : NOP_INSTR;
  assign bus.pc_out         = m_pl.pc;
  assign bus.pred_taken_out = m_pl.pred_taken && (m_valid || !flushed_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushed_q <= 1'b0;
    end else if (flush_i) begin
      flushed_q <= 1'b1;
    end else if (m_valid) begin
      flushed_q <= 1'b0;
    end
  end

  // Counts decode-side backpressure; flush does not touch it, only reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (m_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

endmodule
